dcache_port_arbiter: RTL and testbench
======================================

// Module: dcache_port_arbiter
// PURPOSE
//  Shares the single dcache request port between the two data pipes d1/d2 (post-translation PA).
//  d1 is the older slot of the dual-issue pair; it gets priority.
//  An in-order owner FIFO routes each dcache_data_ok back to the pipe that issued the request.
//  Sits between mmu's translated d1/d2 outputs and the dcache.
// PARAMETERS
//  MAX_OUTST  4  maximum accepted-but-unanswered requests (owner FIFO depth, power of 2)
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous, active-low reset
//  dN_req         in   1   pipe N request valid (N = 1,2; same set per pipe)
//  dN_wr          in   1   pipe N write
//  dN_size        in   2   pipe N access size
//  dN_wstrb       in   4   pipe N byte strobes
//  dN_addr        in   32  pipe N physical address
//  dN_wdata       in   32  pipe N write data
//  dN_uncached    in   1   pipe N uncached access
//  dN_addr_ok     out  1   pipe N request accepted this cycle
//  dN_data_ok     out  1   pipe N response valid this cycle
//  dN_rdata       out  32  pipe N read data
//  dcache_req     out  1   request to dcache
//  dcache_wr, dcache_size, dcache_wstrb, dcache_addr, dcache_wdata, dcache_uncached
//                 out  1/2/4/32/32/1  muxed request fields
//  dcache_addr_ok in   1   dcache accepted request
//  dcache_data_ok in   1   dcache response valid
//  dcache_rdata   in   32  dcache read data
//  outst_cnt      out  $clog2(MAX_OUTST)+1  current FIFO occupancy
//  resp_err       out  1   sticky: data_ok seen with empty FIFO
// BEHAVIOUR
//  - Reset values: all outputs 0; FSM = IDLE; FIFO empty; outst_cnt = 0; resp_err = 0.
//  - FSM states:
//    - IDLE: sel = d1 if d1_req, else d2 if d2_req. dcache_req = selected req && !full.
//      - If dcache_addr_ok this cycle: stay IDLE.
//      - Else, if dcache_req was asserted: go to HOLD_D1 or HOLD_D2 per sel.
//    - HOLD_Dx: request fields are taken from pipe x only (downstream request kept stable), even if the other pipe asserts.
//      - Exit to IDLE on dcache_req && dcache_addr_ok.
//      - If dx_req drops (pipe cancelled), exit to IDLE with no push.
//  - Acceptance: dx_addr_ok = dcache_addr_ok && dcache_req && sel==x (combinational, 0-cycle).
//    - On acceptance, push owner x into the FIFO.
//  - full (cnt == MAX_OUTST): dcache_req = 0 and both addr_ok = 0. No request is lost; it is retried.
//  - Response routing:
//    - dx_data_ok = dcache_data_ok && !empty && head==x (combinational).
//    - dx_rdata = dcache_rdata for both pipes.
//    - On response, pop the FIFO.
//  - Simultaneous push and pop in one cycle: cnt unchanged, and both pointers advance.
//    - Push on full is impossible (gated).
//    - Pop on empty: no pop; set resp_err; both data_ok = 0.
//  - Pointers are log2(MAX_OUTST) bits and wrap modulo MAX_OUTST. cnt saturates at 0..MAX_OUTST.
//  - Same-cycle acceptance and response for the same owner is legal; it pops the older entry.
//  - Reset mid-operation clears the FIFO and FSM immediately (async). dcache must be reset on the same reset.
// STRUCTURE
//  - Package additions (definitions.svh): typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD_D1, ARB_HOLD_D2} dport_arb_state_t;
//    typedef enum logic {OWN_D1, OWN_D2} dport_owner_t.
//  - One sub-module: owner_fifo (1-bit wide, MAX_OUTST deep, push/pop/full/empty/count). The FSM and muxing stay in the top.
// TESTING
//  1. d1 only: d1_req=1, addr=0x1000, addr_ok immediate
//     -> d1_addr_ok same cycle; later data_ok -> d1_data_ok=1, d2_data_ok=0.
//  2. Both req same cycle, addr_ok every cycle
//     -> d1 granted cycle 0, d2 granted cycle 1; responses routed d1 then d2.
//  3. d2 issued, dcache_addr_ok held 0 for 3 cycles while d1_req rises in cycle 1
//     -> dcache_addr stays d2 value until accept (HOLD_D2), then d1 granted.
//  4. MAX_OUTST=4: 4 accepts with no responses
//     -> outst_cnt=4, 5th req sees dcache_req=0; one data_ok frees a slot; the 5th is accepted the next cycle.
//  5. Push and pop same cycle at cnt=2 -> cnt stays 2; 8 more pairs exercise pointer wrap; owners stay in order.
//  6. dcache_data_ok with empty FIFO -> resp_err=1 sticky, no data_ok.
//     Assert reset mid-burst -> cnt=0, resp_err=0, IDLE.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the dcache port arbiter: FSM states, request owner tag
// and the bundled request fields that get muxed onto the dcache port.
package dcache_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_HOLD_D1 = 2'd1,
      ARB_HOLD_D2 = 2'd2
   } dport_arb_state_t;

   typedef enum logic {
      OWN_D1 = 1'b0,
      OWN_D2 = 1'b1
   } dport_owner_t;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        uncached;
   } dport_req_t;

endpackage

// File: rtl/dcache_port_arbiter_owner_fifo.sv
// In-order owner FIFO: one owner tag per accepted dcache request, popped on
// each response so data_ok can be steered back to the issuing pipe.
module dcache_port_arbiter_owner_fifo
   import dcache_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  dport_owner_t             i_push_owner,
   input  logic                     i_pop,
   output dport_owner_t             o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0] r_mem;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr] ? OWN_D2 : OWN_D1;

   // push on full / pop on empty are dropped here as a second line of defence
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= (i_push_owner == OWN_D2);
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single dcache request port between data pipes d1 (older, priority)
// and d2; an owner FIFO routes each dcache data_ok back to its issuing pipe.
module dcache_port_arbiter
   import dcache_port_arbiter_pkg::*;
#(
   parameter int MAX_OUTST = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_d1_req,
   input  logic                        i_d1_wr,
   input  logic [1:0]                  i_d1_size,
   input  logic [3:0]                  i_d1_wstrb,
   input  logic [31:0]                 i_d1_addr,
   input  logic [31:0]                 i_d1_wdata,
   input  logic                        i_d1_uncached,
   output logic                        o_d1_addr_ok,
   output logic                        o_d1_data_ok,
   output logic [31:0]                 o_d1_rdata,
   input  logic                        i_d2_req,
   input  logic                        i_d2_wr,
   input  logic [1:0]                  i_d2_size,
   input  logic [3:0]                  i_d2_wstrb,
   input  logic [31:0]                 i_d2_addr,
   input  logic [31:0]                 i_d2_wdata,
   input  logic                        i_d2_uncached,
   output logic                        o_d2_addr_ok,
   output logic                        o_d2_data_ok,
   output logic [31:0]                 o_d2_rdata,
   output logic                        o_dcache_req,
   output logic                        o_dcache_wr,
   output logic [1:0]                  o_dcache_size,
   output logic [3:0]                  o_dcache_wstrb,
   output logic [31:0]                 o_dcache_addr,
   output logic [31:0]                 o_dcache_wdata,
   output logic                        o_dcache_uncached,
   input  logic                        i_dcache_addr_ok,
   input  logic                        i_dcache_data_ok,
   input  logic [31:0]                 i_dcache_rdata,
   output logic [$clog2(MAX_OUTST):0]  o_outst_cnt,
   output logic                        o_resp_err
);

   dport_arb_state_t r_state;
   logic             r_resp_err;
   dport_owner_t     w_sel;
   logic             w_sel_req;
   dport_req_t       w_d1;
   dport_req_t       w_d2;
   dport_req_t       w_mux;
   logic             w_accept;
   logic             w_resp;
   logic             w_full;
   logic             w_empty;
   dport_owner_t     w_head;

   assign w_d1 = '{wr: i_d1_wr, size: i_d1_size, wstrb: i_d1_wstrb, addr: i_d1_addr,
                   wdata: i_d1_wdata, uncached: i_d1_uncached};
   assign w_d2 = '{wr: i_d2_wr, size: i_d2_size, wstrb: i_d2_wstrb, addr: i_d2_addr,
                   wdata: i_d2_wdata, uncached: i_d2_uncached};

   // once a request is presented but not taken, the owner is locked so the
   // downstream request stays stable even if the other pipe asserts
   always_comb begin
      w_sel = OWN_D1;
      case (r_state)
         ARB_HOLD_D1: w_sel = OWN_D1;
         ARB_HOLD_D2: w_sel = OWN_D2;
         default:     w_sel = i_d1_req ? OWN_D1 : OWN_D2;
      endcase
   end

   assign w_sel_req    = (w_sel == OWN_D1) ? i_d1_req : i_d2_req;
   assign w_mux        = (w_sel == OWN_D1) ? w_d1 : w_d2;
   assign o_dcache_req = w_sel_req && !w_full;
   assign w_accept     = o_dcache_req && i_dcache_addr_ok;
   assign w_resp       = i_dcache_data_ok && !w_empty;

   assign o_dcache_wr       = w_mux.wr;
   assign o_dcache_size     = w_mux.size;
   assign o_dcache_wstrb    = w_mux.wstrb;
   assign o_dcache_addr     = w_mux.addr;
   assign o_dcache_wdata    = w_mux.wdata;
   assign o_dcache_uncached = w_mux.uncached;

   assign o_d1_addr_ok = w_accept && (w_sel == OWN_D1);
   assign o_d2_addr_ok = w_accept && (w_sel == OWN_D2);
   assign o_d1_data_ok = w_resp && (w_head == OWN_D1);
   assign o_d2_data_ok = w_resp && (w_head == OWN_D2);
   assign o_d1_rdata   = i_dcache_rdata;
   assign o_d2_rdata   = i_dcache_rdata;
   assign o_resp_err   = r_resp_err;

   dcache_port_arbiter_owner_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_owner_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push       (w_accept),
      .i_push_owner (w_sel),
      .i_pop        (w_resp),
      .o_head       (w_head),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_count      (o_outst_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ARB_IDLE;
         r_resp_err <= 1'b0;
      end else begin
         if (i_dcache_data_ok && w_empty) begin
            r_resp_err <= 1'b1;
         end
         case (r_state)
            ARB_IDLE: begin
               if (o_dcache_req && !i_dcache_addr_ok) begin
                  r_state <= (w_sel == OWN_D1) ? ARB_HOLD_D1 : ARB_HOLD_D2;
               end
            end
            ARB_HOLD_D1: begin
               if (!i_d1_req || w_accept) r_state <= ARB_IDLE;
            end
            ARB_HOLD_D2: begin
               if (!i_d2_req || w_accept) r_state <= ARB_IDLE;
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed vector table, hand
// sequences for full/wrap/error/reset, then random traffic against a queue model.
module tb_dcache_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        d1_req, d1_wr, d1_uncached, d2_req, d2_wr, d2_uncached;
   logic [1:0]  d1_size, d2_size;
   logic [3:0]  d1_wstrb, d2_wstrb;
   logic [31:0] d1_addr, d1_wdata, d2_addr, d2_wdata;
   logic        d1_addr_ok, d1_data_ok, d2_addr_ok, d2_data_ok;
   logic [31:0] d1_rdata, d2_rdata;
   logic        dc_req, dc_wr, dc_uncached;
   logic [1:0]  dc_size;
   logic [3:0]  dc_wstrb;
   logic [31:0] dc_addr, dc_wdata;
   logic        dc_addr_ok, dc_data_ok;
   logic [31:0] dc_rdata;
   logic [2:0]  outst_cnt;
   logic        resp_err;

   int checks = 0;
   int errors = 0;

   dcache_port_arbiter #(.MAX_OUTST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_d1_req(d1_req), .i_d1_wr(d1_wr), .i_d1_size(d1_size), .i_d1_wstrb(d1_wstrb),
      .i_d1_addr(d1_addr), .i_d1_wdata(d1_wdata), .i_d1_uncached(d1_uncached),
      .o_d1_addr_ok(d1_addr_ok), .o_d1_data_ok(d1_data_ok), .o_d1_rdata(d1_rdata),
      .i_d2_req(d2_req), .i_d2_wr(d2_wr), .i_d2_size(d2_size), .i_d2_wstrb(d2_wstrb),
      .i_d2_addr(d2_addr), .i_d2_wdata(d2_wdata), .i_d2_uncached(d2_uncached),
      .o_d2_addr_ok(d2_addr_ok), .o_d2_data_ok(d2_data_ok), .o_d2_rdata(d2_rdata),
      .o_dcache_req(dc_req), .o_dcache_wr(dc_wr), .o_dcache_size(dc_size),
      .o_dcache_wstrb(dc_wstrb), .o_dcache_addr(dc_addr), .o_dcache_wdata(dc_wdata),
      .o_dcache_uncached(dc_uncached),
      .i_dcache_addr_ok(dc_addr_ok), .i_dcache_data_ok(dc_data_ok), .i_dcache_rdata(dc_rdata),
      .o_outst_cnt(outst_cnt), .o_resp_err(resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        d1, d2, aok, dok;
      logic        e_d1a, e_d2a, e_d1d, e_d2d, e_req;
      logic [2:0]  e_cnt;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic r1, input logic r2, input logic aok, input logic dok);
      d1_req = r1; d2_req = r2; dc_addr_ok = aok; dc_data_ok = dok;
   endtask

   task automatic add(input logic d1, input logic d2, input logic aok, input logic dok,
                      input logic e_d1a, input logic e_d2a, input logic e_d1d,
                      input logic e_d2d, input logic e_req, input logic [2:0] e_cnt,
                      input logic [31:0] e_addr);
      vec_t v;
      v.d1 = d1; v.d2 = d2; v.aok = aok; v.dok = dok;
      v.e_d1a = e_d1a; v.e_d2a = e_d2a; v.e_d1d = e_d1d; v.e_d2d = e_d2d;
      v.e_req = e_req; v.e_cnt = e_cnt; v.e_addr = e_addr;
      vecs.push_back(v);
   endtask

   // reference model state
   int  mq[$];
   int  held;
   bit  merr;

   initial begin
      int q[$];
      int head, own;
      rst_n = 1'b0;
      d1_req = 0; d1_wr = 0; d1_size = 0; d1_wstrb = 0; d1_addr = 0; d1_wdata = 0; d1_uncached = 0;
      d2_req = 0; d2_wr = 0; d2_size = 0; d2_wstrb = 0; d2_addr = 0; d2_wdata = 0; d2_uncached = 0;
      dc_addr_ok = 0; dc_data_ok = 0; dc_rdata = 0;
      #2;
      chk("reset_ctrl", {d1_addr_ok, d2_addr_ok, d1_data_ok, d2_data_ok, dc_req, outst_cnt, resp_err}, 64'h0);
      chk("reset_addr", dc_addr, 0);
      step();
      rst_n = 1'b1;
      d1_addr = 32'h1000; d2_addr = 32'h2000;

      // d1 only, then both pipes, then held d2 with late d1, then cancelled hold
      add(0,0,0,0, 0,0,0,0,0, 0, 0);
      add(1,0,1,0, 1,0,0,0,1, 0, 32'h1000);
      add(0,0,0,1, 0,0,1,0,0, 1, 0);
      add(0,0,0,0, 0,0,0,0,0, 0, 0);
      add(1,1,1,0, 1,0,0,0,1, 0, 32'h1000);
      add(0,1,1,0, 0,1,0,0,1, 1, 32'h2000);
      add(0,0,0,1, 0,0,1,0,0, 2, 0);
      add(0,0,0,1, 0,0,0,1,0, 1, 0);
      add(0,0,0,0, 0,0,0,0,0, 0, 0);
      add(0,1,0,0, 0,0,0,0,1, 0, 32'h2000);
      add(1,1,0,0, 0,0,0,0,1, 0, 32'h2000);
      add(1,1,0,0, 0,0,0,0,1, 0, 32'h2000);
      add(1,1,1,0, 0,1,0,0,1, 0, 32'h2000);
      add(1,0,1,0, 1,0,0,0,1, 1, 32'h1000);
      add(0,0,0,1, 0,0,0,1,0, 2, 0);
      add(0,0,0,1, 0,0,1,0,0, 1, 0);
      add(0,0,0,0, 0,0,0,0,0, 0, 0);
      add(1,0,0,0, 0,0,0,0,1, 0, 32'h1000);
      add(0,1,0,0, 0,0,0,0,0, 0, 0);
      add(0,1,1,0, 0,1,0,0,1, 0, 32'h2000);
      add(0,0,0,1, 0,0,0,1,0, 1, 0);
      add(0,0,0,0, 0,0,0,0,0, 0, 0);

      foreach (vecs[i]) begin
         set_in(vecs[i].d1, vecs[i].d2, vecs[i].aok, vecs[i].dok);
         #2;
         chk($sformatf("vec%0d_ctrl", i),
             {d1_addr_ok, d2_addr_ok, d1_data_ok, d2_data_ok, dc_req, outst_cnt, resp_err},
             {vecs[i].e_d1a, vecs[i].e_d2a, vecs[i].e_d1d, vecs[i].e_d2d, vecs[i].e_req, vecs[i].e_cnt, 1'b0});
         if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i), dc_addr, vecs[i].e_addr);
         step();
      end

      // fill to MAX_OUTST, blocked 5th request, freed slot, retry
      for (int i = 0; i < 4; i++) begin
         set_in(1,0,1,0); #2; chk("full_fill_aok", d1_addr_ok, 1); step();
      end
      set_in(1,0,1,0); #2;
      chk("full_cnt", outst_cnt, 4);
      chk("full_blocked", {dc_req, d1_addr_ok, d2_addr_ok}, 0);
      step();
      set_in(1,0,1,1); #2;
      chk("full_resp", {dc_req, d1_addr_ok, d1_data_ok}, 3'b001);
      step();
      set_in(1,0,1,0); #2;
      chk("full_retry_cnt", outst_cnt, 3);
      chk("full_retry_aok", {dc_req, d1_addr_ok}, 2'b11);
      step();
      for (int i = 0; i < 4; i++) begin
         set_in(0,0,0,1); #2; chk("full_drain", d1_data_ok, 1); step();
      end
      set_in(0,0,0,0); #2; chk("full_empty_cnt", outst_cnt, 0);

      // push+pop at cnt=2 across pointer wrap
      set_in(1,0,1,0); step();
      set_in(0,1,1,0); step();
      q = '{1, 2};
      for (int i = 0; i < 9; i++) begin
         own = (i % 2 == 0) ? 1 : 2;
         set_in(own == 1, own == 2, 1, 1); #2;
         head = q.pop_front();
         chk("pp_cnt", outst_cnt, 2);
         chk("pp_route", {d1_data_ok, d2_data_ok, d1_addr_ok, d2_addr_ok},
             {head == 1, head == 2, own == 1, own == 2});
         q.push_back(own);
         step();
      end
      while (q.size() > 0) begin
         head = q.pop_front();
         set_in(0,0,0,1); #2;
         chk("pp_drain", {d1_data_ok, d2_data_ok}, {head == 1, head == 2});
         step();
      end

      // response with empty FIFO, then async reset mid-burst
      set_in(0,0,0,1); #2;
      chk("err_no_dok", {d1_data_ok, d2_data_ok, resp_err}, 0);
      step();
      set_in(0,0,0,0); #2; chk("err_set", resp_err, 1); step();
      #2; chk("err_sticky", resp_err, 1);
      set_in(1,0,1,0); step();
      set_in(0,1,0,0); step();
      set_in(1,1,0,0); #2;
      chk("rst_pre_hold", {dc_addr, outst_cnt}, {32'h2000, 3'd1});
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid", {outst_cnt, resp_err, dc_addr}, {3'd0, 1'b0, 32'h1000});
      step();
      rst_n = 1'b1;
      set_in(1,1,1,0); #2;
      chk("rst_idle_grant", {d1_addr_ok, d2_addr_ok}, 2'b10);
      step();
      set_in(0,0,0,1); step();
      set_in(0,0,0,0);
      rst_n = 1'b0; step(); rst_n = 1'b1;

      // random traffic against a queue/arithmetic model
      held = 0; merr = 0; mq = {};
      for (int c = 0; c < 600; c++) begin
         int sel, r1i, r2i;
         bit exp_req, acc, rd1, rd2;
         logic [31:0] e_addr, e_wdata;
         logic [7:0]  e_misc;
         r1i = ($urandom_range(0, 9) < 5) ? 1 : 0;
         r2i = ($urandom_range(0, 9) < 5) ? 1 : 0;
         d1_req = r1i[0]; d2_req = r2i[0];
         d1_addr = $urandom; d1_wdata = $urandom; d1_wr = $urandom_range(0,1);
         d1_size = 2'($urandom_range(0,3)); d1_wstrb = 4'($urandom_range(0,15));
         d1_uncached = $urandom_range(0,1);
         d2_addr = $urandom; d2_wdata = $urandom; d2_wr = $urandom_range(0,1);
         d2_size = 2'($urandom_range(0,3)); d2_wstrb = 4'($urandom_range(0,15));
         d2_uncached = $urandom_range(0,1);
         dc_rdata = $urandom;
         dc_addr_ok = $urandom_range(0,1);
         dc_data_ok = (mq.size() > 0) ? ($urandom_range(0,9) < 4) : ($urandom_range(0,39) == 0);

         sel = (held != 0) ? held : (r1i ? 1 : (r2i ? 2 : 0));
         exp_req = (sel == 1 && r1i == 1 || sel == 2 && r2i == 1) && mq.size() < 4;
         acc = exp_req && dc_addr_ok;
         rd1 = dc_data_ok && mq.size() > 0 && mq[0] == 1;
         rd2 = dc_data_ok && mq.size() > 0 && mq[0] == 2;
         e_addr  = (sel == 1) ? d1_addr : d2_addr;
         e_wdata = (sel == 1) ? d1_wdata : d2_wdata;
         e_misc  = (sel == 1) ? {d1_wr, d1_size, d1_wstrb, d1_uncached}
                              : {d2_wr, d2_size, d2_wstrb, d2_uncached};
         #2;
         chk("rnd_ctrl", {d1_addr_ok, d2_addr_ok, d1_data_ok, d2_data_ok, dc_req, outst_cnt, resp_err},
             {acc && sel == 1, acc && sel == 2, rd1, rd2, exp_req, 3'(mq.size()), merr});
         chk("rnd_rdata", {d1_rdata, d2_rdata}, {dc_rdata, dc_rdata});
         if (exp_req) begin
            chk("rnd_addr", dc_addr, e_addr);
            chk("rnd_wdata", dc_wdata, e_wdata);
            chk("rnd_misc", {dc_wr, dc_size, dc_wstrb, dc_uncached}, e_misc);
         end
         if (dc_data_ok) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else merr = 1;
         end
         if (acc) mq.push_back(sel);
         if (acc) held = 0;
         else if (held == 1 && r1i == 0 || held == 2 && r2i == 0) held = 0;
         else if (held == 0 && exp_req) held = sel;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
